// File: rtl/tracesys_pkg.sv
// Shared types and constants for the trace-system capture path.
package tracesys_pkg;

    localparam int unsigned TRACE_ADDR_W = 13;
    localparam int unsigned TRACE_DATA_W = 32;
    localparam int unsigned TRACE_DEPTH  = 2 ** TRACE_ADDR_W;
    localparam int unsigned BE_W         = 4;
    localparam logic [BE_W-1:0] BE_ALL   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/tracesys_wr_stage.sv
// One-stage registered Avalon-MM write initiator; a beat presented on wr_en
// appears on the memory port in the following cycle.
module tracesys_wr_stage
    import tracesys_pkg::*;
#(
    parameter int unsigned ADDR_W = TRACE_ADDR_W,
    parameter int unsigned DATA_W = TRACE_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
        end else begin
            mem_write      <= wr_en;
            mem_chipselect <= wr_en;
            mem_byteenable <= BE_ALL;
            if (wr_en) begin
                mem_address   <= wr_addr;
                mem_writedata <= wr_data;
            end
        end
    end

endmodule

// File: rtl/tracesys_capture_writer.sv
// Fills trace memory from an Avalon-ST capture stream under arm/trigger/abort
// control. Define TRACESYS_WRAP_EN for circular pre-trigger history capture.
module tracesys_capture_writer
    import tracesys_pkg::*;
#(
    parameter int unsigned ADDR_W    = TRACE_ADDR_W,
    parameter int unsigned DATA_W    = TRACE_DATA_W,
    parameter int unsigned DEPTH     = TRACE_DEPTH,
    parameter int unsigned POST_TRIG = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              trigger,
    input  logic              abort,
    input  logic              snk_valid,
    input  logic [DATA_W-1:0] snk_data,
    output logic              snk_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W:0]   beat_count,
    output logic              overflow
);

`ifdef TRACESYS_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned LIMIT = WRAP_EN ? POST_TRIG : DEPTH;

    state_e           state;
    state_e           state_nxt;
    logic             accept;
    logic             wr_en;
    logic             start;
    logic             last_beat;
    logic [CNT_W-1:0] post_cnt;

    assign accept    = snk_valid & snk_ready;
    assign start     = ((state == ST_IDLE) | (state == ST_DONE)) & arm & ~abort;
    assign last_beat = (post_cnt == CNT_W'(LIMIT - 1));

    // ARMED beats are only stored when building pre-trigger history
    always_comb begin
        wr_en = accept & ((state == ST_CAPTURE) | (WRAP_EN & (state == ST_ARMED)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (arm)               state_nxt = ST_ARMED;
                ST_ARMED:         if (trigger)           state_nxt = ST_CAPTURE;
                ST_CAPTURE:       if (accept & last_beat) state_nxt = ST_DONE;
                default:          state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        snk_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_ARMED, ST_CAPTURE: begin
                snk_ready = 1'b1;
                busy      = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Write pointer wraps naturally since DEPTH == 2**ADDR_W
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            beat_count <= '0;
            post_cnt   <= '0;
        end else if (start) begin
            wr_ptr     <= '0;
            beat_count <= '0;
            post_cnt   <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (beat_count != CNT_W'(DEPTH)) beat_count <= beat_count + CNT_W'(1);
            if (state == ST_CAPTURE)         post_cnt   <= post_cnt + CNT_W'(1);
        end
    end

`ifdef TRACESYS_WRAP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_addr <= '0;
            overflow  <= 1'b0;
        end else if (start) begin
            trig_addr <= '0;
            overflow  <= 1'b0;
        end else begin
            if ((state == ST_ARMED) & trigger & ~abort) trig_addr <= wr_ptr;
            if (wr_en & (state == ST_ARMED) & (wr_ptr == '1)) overflow <= 1'b1;
        end
    end
`else
    assign trig_addr = '0;
    assign overflow  = 1'b0;
`endif

    tracesys_wr_stage #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr_stage (
        .clk            (clk),
        .reset_n        (reset_n),
        .wr_en          (wr_en),
        .wr_addr        (wr_ptr),
        .wr_data        (snk_data),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata)
    );

endmodule

// File: tb/tb_tracesys_capture_writer.sv
// Randomised self-checking bench for tracesys_capture_writer against a
// transaction-level reference model (follows TRACESYS_WRAP_EN like the DUT).
module tb_tracesys_capture_writer;

    localparam int ADDR_W    = 13;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 8192;
    localparam int POST_TRIG = 16;
`ifdef TRACESYS_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam int LIMIT = WRAP ? POST_TRIG : DEPTH;

    localparam int P_IDLE  = 0;
    localparam int P_ARMED = 1;
    localparam int P_CAPT  = 2;
    localparam int P_DONE  = 3;

    logic              clk;
    logic              reset_n;
    logic              arm;
    logic              trigger;
    logic              abort;
    logic              snk_valid;
    logic [DATA_W-1:0] snk_data;
    logic              snk_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W:0]   beat_count;
    logic              overflow;

    tracesys_capture_writer #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .POST_TRIG (POST_TRIG)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .arm            (arm),
        .trigger        (trigger),
        .abort          (abort),
        .snk_valid      (snk_valid),
        .snk_data       (snk_data),
        .snk_ready      (snk_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .busy           (busy),
        .done           (done),
        .wr_ptr         (wr_ptr),
        .trig_addr      (trig_addr),
        .beat_count     (beat_count),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;
    int bus_err;

    int m_phase;
    int m_ptr;
    int m_trig;
    int m_cnt;
    int m_post;
    bit m_ovf;

    logic [ADDR_W+DATA_W-1:0] exp_wr[$];
    logic [ADDR_W+DATA_W-1:0] act_wr[$];
    logic [DATA_W-1:0]        mem_img[DEPTH];

    logic [43:0] dut_status;
    assign dut_status = {busy, done, snk_ready, wr_ptr, trig_addr, beat_count, overflow};

    // Slave side: log every write the memory would see
    always @(negedge clk) begin
        if (mem_chipselect !== mem_write) bus_err++;
        if (mem_write === 1'b1) begin
            if (mem_byteenable !== 4'hF) bus_err++;
            act_wr.push_back({mem_address, mem_writedata});
            mem_img[mem_address] = mem_writedata;
        end
    end

    function automatic logic [43:0] exp_status();
        bit act;
        act = (m_phase == P_ARMED) || (m_phase == P_CAPT);
        return {act, m_phase == P_DONE, act, ADDR_W'(m_ptr), ADDR_W'(m_trig),
                (ADDR_W+1)'(m_cnt), m_ovf};
    endfunction

    // -1 when logs agree, -2 on length difference, else first differing index
    function automatic int wr_diff();
        if (act_wr.size() != exp_wr.size()) return -2;
        foreach (act_wr[i]) if (act_wr[i] !== exp_wr[i]) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        m_phase = P_IDLE; m_ptr = 0; m_trig = 0; m_cnt = 0; m_post = 0; m_ovf = 1'b0;
    endfunction

    // Drive one clock of stimulus and advance the reference model
    task automatic cycle(input bit a, input bit t, input bit ab, input bit v,
                         input logic [DATA_W-1:0] d);
        bit rdy;
        bit wr;
        int old_ptr;
        arm = a; trigger = t; abort = ab; snk_valid = v; snk_data = d;
        rdy     = (m_phase == P_ARMED) || (m_phase == P_CAPT);
        wr      = v && rdy && ((m_phase == P_CAPT) || (WRAP && m_phase == P_ARMED));
        old_ptr = m_ptr;
        if (wr) begin
            exp_wr.push_back({ADDR_W'(m_ptr), d});
            if (m_phase == P_ARMED && m_ptr == DEPTH - 1) m_ovf = 1'b1;
            m_ptr = (m_ptr + 1) % DEPTH;
            if (m_cnt < DEPTH) m_cnt++;
            if (m_phase == P_CAPT) m_post++;
        end
        if (ab) m_phase = P_IDLE;
        else if ((m_phase == P_IDLE || m_phase == P_DONE) && a) begin
            m_phase = P_ARMED; m_ptr = 0; m_cnt = 0; m_trig = 0; m_ovf = 1'b0; m_post = 0;
        end else if (m_phase == P_ARMED && t) begin
            m_phase = P_CAPT;
            if (WRAP) m_trig = old_ptr;
        end else if (m_phase == P_CAPT && m_post == LIMIT) m_phase = P_DONE;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        arm = 0; trigger = 0; abort = 0; snk_valid = 0; snk_data = '0;
        bus_err = 0;
        model_reset();
        #22;
        tests++;
        if ({dut_status, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got status=%h addr=%h be=%h cs=%b wr=%b data=%h, expected all zero",
                     dut_status, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata);
        end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (dut_status !== exp_status()) begin
            fails++;
            $display("FAIL reset_release_status: got %h expected %h", dut_status, exp_status());
        end
    endtask

    task automatic test_full_capture();
        int i;
        int guard;
        int bad;
        int n;
        i = 0; guard = 0;
        cycle(1, 0, 0, 0, '0);
        cycle(0, 1, 0, 0, '0);
        while (m_phase != P_DONE && guard < 4 * DEPTH) begin
            bit v;
            v = ($urandom_range(0, 3) != 0);
            cycle(0, 0, 0, v, DATA_W'(i));
            if (v) i++;
            guard++;
        end
        tests++;
        if ({mem_write, done} !== 2'b11) begin
            fails++;
            $display("FAIL final_write_with_done: got write,done=%b%b expected 11 (model phase %0d)",
                     mem_write, done, m_phase);
        end
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, $urandom);
        tests++;
        if (dut_status !== exp_status() || snk_ready !== 1'b0) begin
            fails++;
            $display("FAIL capture_done_status: got %h expected %h", dut_status, exp_status());
        end
        tests++;
        if (beat_count !== (ADDR_W+1)'(LIMIT)) begin
            fails++;
            $display("FAIL capture_beat_count: got %0d expected %0d", beat_count, LIMIT);
        end
        tests++;
        if (wr_diff() != -1) begin
            fails++;
            $display("FAIL capture_writes: diff=%0d got %0d writes expected %0d",
                     wr_diff(), act_wr.size(), exp_wr.size());
        end
        bad = 0;
        n = LIMIT;
        for (int k = 0; k < n; k++) if (mem_img[k] !== DATA_W'(k)) bad++;
        tests++;
        if (bad != 0 || bus_err != 0) begin
            fails++;
            $display("FAIL capture_memory_image: got %0d bad words, %0d bus errors, expected 0", bad, bus_err);
        end
        act_wr.delete(); exp_wr.delete();
    endtask

    task automatic test_armed_discard();
        int exp_n;
        int idx;
        exp_n = WRAP ? 100 : 0;
        cycle(1, 0, 0, 0, '0);
        for (int k = 0; k < 100; k++) cycle(0, 0, 0, 1, $urandom);
        cycle(0, 0, 0, 0, '0);
        tests++;
        if (act_wr.size() !== exp_n || dut_status !== exp_status()) begin
            fails++;
            $display("FAIL armed_writes: got %0d writes status %h expected %0d writes status %h",
                     act_wr.size(), dut_status, exp_n, exp_status());
        end
        cycle(0, 1, 0, 0, '0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, $urandom);
        cycle(0, 0, 1, 0, '0);
        cycle(0, 0, 0, 0, '0);
        idx = exp_n;
        tests++;
        if (wr_diff() != -1 || act_wr.size() <= idx ||
            act_wr[idx][ADDR_W+DATA_W-1:DATA_W] !== ADDR_W'(exp_n)) begin
            fails++;
            $display("FAIL first_post_trigger_addr: diff=%0d got %0d writes expected %0d, first addr expected %0d",
                     wr_diff(), act_wr.size(), exp_wr.size(), exp_n);
        end
        act_wr.delete(); exp_wr.delete();
    endtask

    task automatic test_abort();
        cycle(1, 0, 0, 0, '0);
        cycle(0, 1, 0, 0, '0);
        for (int k = 0; k < 5; k++) cycle(0, 0, 0, 1, $urandom);
        cycle(0, 0, 1, 1, 32'hA5A5_0006);
        tests++;
        if (dut_status !== exp_status() || snk_ready !== 1'b0 || mem_write !== 1'b1 ||
            mem_address !== ADDR_W'(5) || mem_writedata !== 32'hA5A5_0006) begin
            fails++;
            $display("FAIL abort_cycle: got status %h wr=%b addr=%0d data=%h expected status %h wr=1 addr=5 data=a5a50006",
                     dut_status, mem_write, mem_address, mem_writedata, exp_status());
        end
        cycle(0, 0, 0, 0, '0);
        tests++;
        if (wr_diff() != -1 || act_wr.size() !== 6) begin
            fails++;
            $display("FAIL abort_writes: diff=%0d got %0d writes expected 6", wr_diff(), act_wr.size());
        end
        cycle(1, 0, 1, 0, '0);
        tests++;
        if (busy !== 1'b0 || dut_status !== exp_status()) begin
            fails++;
            $display("FAIL arm_with_abort: got busy=%b status %h expected busy=0 status %h",
                     busy, dut_status, exp_status());
        end
        act_wr.delete(); exp_wr.delete();
    endtask

    task automatic test_wrap_history();
        cycle(1, 0, 0, 0, '0);
        for (int k = 0; k < 10000; k++) cycle(0, 0, 0, 1, $urandom);
        cycle(0, 1, 0, 0, '0);
        tests++;
        if (trig_addr !== ADDR_W'(WRAP ? 1808 : 0) || overflow !== WRAP) begin
            fails++;
            $display("FAIL wrap_trigger: got trig_addr=%0d overflow=%b expected %0d %b",
                     trig_addr, overflow, WRAP ? 1808 : 0, WRAP);
        end
        for (int k = 0; k < 20; k++) cycle(0, 0, 0, 1, $urandom);
        cycle(0, 0, 0, 0, '0);
        tests++;
        if (dut_status !== exp_status() || wr_diff() != -1) begin
            fails++;
            $display("FAIL wrap_post_capture: got status %h expected %h, write diff=%0d",
                     dut_status, exp_status(), wr_diff());
        end
        cycle(0, 0, 1, 0, '0);
        act_wr.delete(); exp_wr.delete();
    endtask

    task automatic test_ptr_wrap();
        int base;
        int bad;
        base = WRAP ? 8190 : 0;
        bad  = 0;
        cycle(1, 0, 0, 0, '0);
        for (int k = 0; k < 8190; k++) cycle(0, 0, 0, 1, $urandom);
        cycle(0, 1, 0, 0, '0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, $urandom);
        cycle(0, 0, 1, 0, '0);
        cycle(0, 0, 0, 0, '0);
        if (act_wr.size() < base + 4) bad = 1;
        else for (int k = 0; k < 4; k++)
            if (act_wr[base+k][ADDR_W+DATA_W-1:DATA_W] !== ADDR_W'((base + k) % DEPTH)) bad++;
        tests++;
        if (bad != 0 || wr_diff() != -1) begin
            fails++;
            $display("FAIL pointer_wrap: got %0d bad addresses, write diff=%0d, %0d writes (expected %0d)",
                     bad, wr_diff(), act_wr.size(), exp_wr.size());
        end
        act_wr.delete(); exp_wr.delete();
    endtask

    task automatic test_random();
        bit ok;
        ok = 1'b1;
        for (int c = 0; c < 3000 && ok; c++) begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 149) == 0, $urandom_range(0, 2) != 0, $urandom);
            tests++;
            if (dut_status !== exp_status()) begin
                fails++;
                ok = 1'b0;
                $display("FAIL random_status cycle %0d: got %h expected %h", c, dut_status, exp_status());
            end
        end
        cycle(0, 0, 1, 0, '0);
        cycle(0, 0, 0, 0, '0);
        tests++;
        if (wr_diff() != -1 || bus_err != 0) begin
            fails++;
            $display("FAIL random_writes: diff=%0d got %0d writes expected %0d, bus errors %0d",
                     wr_diff(), act_wr.size(), exp_wr.size(), bus_err);
        end
        act_wr.delete(); exp_wr.delete();
    endtask

    task automatic test_reset_mid();
        cycle(1, 0, 0, 0, '0);
        cycle(0, 1, 0, 0, '0);
        for (int k = 0; k < 7; k++) cycle(0, 0, 0, 1, $urandom);
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({dut_status, mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata} !== '0) begin
            fails++;
            $display("FAIL async_reset_outputs: got status=%h addr=%h be=%h wr=%b data=%h expected all zero",
                     dut_status, mem_address, mem_byteenable, mem_write, mem_writedata);
        end
        act_wr.delete(); exp_wr.delete();
        model_reset();
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) cycle(0, 0, 0, 1, $urandom);
        tests++;
        if (act_wr.size() !== 0 || dut_status !== exp_status()) begin
            fails++;
            $display("FAIL post_reset_quiet: got %0d writes status %h expected 0 writes status %h",
                     act_wr.size(), dut_status, exp_status());
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_full_capture();
        test_armed_discard();
        test_abort();
        test_wrap_history();
        test_ptr_wrap();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
